// File: rtl/axis_pkt_pkg.sv
// Shared definitions for the length-prefixed AXI-Stream packet format.
// The same header layout is used by the packetiser on the transmit side
// and by the parser on the receive side.
//
// Contents:
//   HDR_ID_MSB/LSB   bit range of the 8-bit packet ID in the header word
//   HDR_LEN_MSB/LSB  bit range of the 16-bit payload length in the header word
//   pkt_hdr_t        packed view of a 64-bit header word {id, rsvd, len}
//   parser_state_t   receive FSM states
package axis_pkt_pkg;

   localparam int HDR_ID_MSB  = 63;
   localparam int HDR_ID_LSB  = 56;
   localparam int HDR_LEN_MSB = 15;
   localparam int HDR_LEN_LSB = 0;

   typedef struct packed {
      logic [7:0]  id;
      logic [39:0] rsvd;
      logic [15:0] len;
   } pkt_hdr_t;

   typedef enum logic [1:0] {
      S_HDR  = 2'd0,
      S_PAY  = 2'd1,
      S_DROP = 2'd2
   } parser_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer for a valid/ready stream.
// Data written on a clock edge is presented on the output after that edge,
// giving one cycle of latency, and one word per cycle flows through while
// the consumer keeps i_ready high.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (empties the buffer)
//   i_data/i_valid producer side, o_ready = buffer not full
//   o_data/o_valid consumer side, i_ready = consumer ready
module axis_skid_buffer #(
   parameter int WIDTH = 65
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready
);

   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   assign o_ready = (r_count != 2'd2);
   assign o_valid = (r_count != 2'd0);
   assign o_data  = r_head;
   assign w_push  = i_valid && o_ready;
   assign w_pop   = o_valid && i_ready;

   // r_head is always the word on the output. A simultaneous push and pop
   // can only happen with exactly one entry held (push needs a free slot,
   // pop needs an occupied one), so the new word replaces the head directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_head <= i_data;
               end else begin
                  r_tail <= i_data;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_head  <= r_tail;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               r_head <= i_data;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/axi_stream_len_parser.sv
// Receive-side parser for length-prefixed 64-bit AXI-Stream packets.
// Strips the header word, checks ID and length, forwards the payload with a
// regenerated tlast and keeps good-packet and error counters.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ena                         accept new packets (looked at only between packets)
//   clear_counters              synchronous clear of pkt_count and err_count
//   in_tdata/tvalid/tlast/tready   upstream stream (header + payload)
//   out_tdata/tvalid/tlast/tready  payload stream with length-correct tlast
//   pkt_len                     length field of the most recent header
//   pkt_count                   good packets forwarded (wraps)
//   err_count                   packets with an error (saturates)
//   err_pulse                   one-cycle pulse per error event
//   busy                        parser is inside a packet
module axi_stream_len_parser
   import axis_pkt_pkg::*;
#(
   parameter logic [7:0] ID          = 8'hF0,
   parameter int         MAX_PKT_LEN = 64,
   parameter int         CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   input  logic                 clear_counters,
   input  logic [63:0]          in_tdata,
   input  logic                 in_tvalid,
   input  logic                 in_tlast,
   output logic                 in_tready,
   output logic [63:0]          out_tdata,
   output logic                 out_tvalid,
   output logic                 out_tlast,
   input  logic                 out_tready,
   output logic [15:0]          pkt_len,
   output logic [31:0]          pkt_count,
   output logic [CNT_WIDTH-1:0] err_count,
   output logic                 err_pulse,
   output logic                 busy
);

   parser_state_t        r_state;
   parser_state_t        w_next_state;
   logic [15:0]          r_remaining;
   logic [15:0]          r_pkt_len;
   logic [31:0]          r_pkt_count;
   logic [CNT_WIDTH-1:0] r_err_count;
   logic                 r_err_pulse;

   logic [7:0]           w_hdr_id;
   logic [15:0]          w_hdr_len;
   logic                 w_hdr_bad;
   logic                 w_last_word;
   logic                 w_beat;
   logic                 w_in_tready;
   logic                 w_fwd;
   logic                 w_err_event;
   logic                 w_good_pkt;
   logic                 w_skid_ready;
   logic [64:0]          w_skid_out;

   assign w_hdr_id    = in_tdata[HDR_ID_MSB:HDR_ID_LSB];
   assign w_hdr_len   = in_tdata[HDR_LEN_MSB:HDR_LEN_LSB];
   assign w_hdr_bad   = (w_hdr_id != ID) || (w_hdr_len == 16'd0) ||
                        (w_hdr_len > 16'(MAX_PKT_LEN));
   assign w_last_word = (r_remaining == 16'd1);
   assign w_beat      = in_tvalid && w_in_tready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_HDR;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic. A header carrying tlast is a complete (if faulty)
   // packet, so the parser stays ready for the next header in that case.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_HDR: begin
            if (w_beat) begin
               if (in_tlast) begin
                  w_next_state = S_HDR;
               end else if (w_hdr_bad) begin
                  w_next_state = S_DROP;
               end else begin
                  w_next_state = S_PAY;
               end
            end
         end
         S_PAY: begin
            if (w_beat) begin
               if (in_tlast) begin
                  w_next_state = S_HDR;
               end else if (w_last_word) begin
                  w_next_state = S_DROP;
               end
            end
         end
         S_DROP: begin
            if (w_beat && in_tlast) begin
               w_next_state = S_HDR;
            end
         end
         default: begin
            w_next_state = S_HDR;
         end
      endcase
   end

   // Output decode. Handshake terms are written out per state rather than
   // through w_beat so that in_tready never feeds back into itself.
   // Every faulty packet raises exactly one error event: at its header, at
   // a truncating tlast, or at the word where an overrun is detected (the
   // rest of an overrun packet is then swallowed silently in S_DROP).
   always_comb begin
      w_in_tready = 1'b0;
      w_fwd       = 1'b0;
      w_err_event = 1'b0;
      w_good_pkt  = 1'b0;
      case (r_state)
         S_HDR: begin
            w_in_tready = ena;
            w_err_event = in_tvalid && ena && (w_hdr_bad || in_tlast);
         end
         S_PAY: begin
            w_in_tready = w_skid_ready;
            if (in_tvalid && w_skid_ready) begin
               w_fwd = 1'b1;
               if (in_tlast && w_last_word) begin
                  w_good_pkt = 1'b1;
               end else if (in_tlast || w_last_word) begin
                  w_err_event = 1'b1;
               end
            end
         end
         S_DROP: begin
            w_in_tready = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Header capture and payload word countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_len   <= 16'd0;
         r_remaining <= 16'd0;
         r_err_pulse <= 1'b0;
      end else begin
         if ((r_state == S_HDR) && w_beat) begin
            r_pkt_len   <= w_hdr_len;
            r_remaining <= w_hdr_len;
         end else if (w_fwd) begin
            r_remaining <= r_remaining - 16'd1;
         end
         r_err_pulse <= w_err_event;
      end
   end

   // Statistics counters; a clear wins over an increment in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pkt_count <= 32'd0;
         r_err_count <= '0;
      end else if (clear_counters) begin
         r_pkt_count <= 32'd0;
         r_err_count <= '0;
      end else begin
         if (w_good_pkt) begin
            r_pkt_count <= r_pkt_count + 32'd1;
         end
         if (w_err_event && (r_err_count != '1)) begin
            r_err_count <= r_err_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   // tlast is regenerated from the header length, but an early upstream
   // tlast still closes the output packet so downstream never hangs.
   axis_skid_buffer #(
      .WIDTH (65)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  ({in_tlast || w_last_word, in_tdata}),
      .i_valid (w_fwd),
      .o_ready (w_skid_ready),
      .o_data  (w_skid_out),
      .o_valid (out_tvalid),
      .i_ready (out_tready)
   );

   assign in_tready = w_in_tready;
   assign out_tdata = w_skid_out[63:0];
   assign out_tlast = w_skid_out[64];
   assign pkt_len   = r_pkt_len;
   assign pkt_count = r_pkt_count;
   assign err_count = r_err_count;
   assign err_pulse = r_err_pulse;
   assign busy      = (r_state != S_HDR);

endmodule

// File: tb/tb_axi_stream_len_parser.sv
// Self-checking bench for axi_stream_len_parser.
// Packets are driven at packet level; expected output beats are queued and
// matched by a monitor, counters are compared against running totals.
// The DUT is built with 4-bit error counters so saturation is reachable.
module tb_axi_stream_len_parser;
   import axis_pkt_pkg::*;

   localparam int TB_CNT_W = 4;
   localparam int ERR_MAX  = (1 << TB_CNT_W) - 1;
   localparam int MAX_LEN  = 64;
   localparam logic [7:0] GOOD_ID = 8'hF0;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                ena = 1'b0;
   logic                clear_counters = 1'b0;
   logic [63:0]         in_tdata = '0;
   logic                in_tvalid = 1'b0;
   logic                in_tlast = 1'b0;
   logic                in_tready;
   logic [63:0]         out_tdata;
   logic                out_tvalid;
   logic                out_tlast;
   logic                out_tready;
   logic [15:0]         pkt_len;
   logic [31:0]         pkt_count;
   logic [TB_CNT_W-1:0] err_count;
   logic                err_pulse;
   logic                busy;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
   } beat_t;

   typedef struct {
      logic [7:0] id;
      int         len;
      int         nWords;
      bit         hdrLast;
      int         expOut;
      int         expErr;
      int         expPkt;
   } vec_t;

   beat_t       expQ[$];
   int          checks = 0;
   int          failures = 0;
   int          expErrTot = 0;
   int          expPulseTot = 0;
   logic [31:0] expPktTot = '0;
   int          pulseSeen = 0;
   int          readyMode = 0;

   axi_stream_len_parser #(
      .ID          (GOOD_ID),
      .MAX_PKT_LEN (MAX_LEN),
      .CNT_WIDTH   (TB_CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ena            (ena),
      .clear_counters (clear_counters),
      .in_tdata       (in_tdata),
      .in_tvalid      (in_tvalid),
      .in_tlast       (in_tlast),
      .in_tready      (in_tready),
      .out_tdata      (out_tdata),
      .out_tvalid     (out_tvalid),
      .out_tlast      (out_tlast),
      .out_tready     (out_tready),
      .pkt_len        (pkt_len),
      .pkt_count      (pkt_count),
      .err_count      (err_count),
      .err_pulse      (err_pulse),
      .busy           (busy)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Downstream ready pattern: 0 = always ready, 1 = toggling, 2 = random
   initial begin
      out_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       out_tready = 1'b1;
            1:       out_tready = ~out_tready;
            default: out_tready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor on the falling edge: matches each transfer against the
   // expected queue, checks stability while stalled and counts err_pulse.
   logic        prevStall = 1'b0;
   logic [63:0] prevData = '0;
   logic        prevLast = 1'b0;
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) begin
            checks++;
            if (!(out_tvalid && out_tdata == prevData && out_tlast == prevLast)) begin
               failures++;
               $display("[TB] FAIL stall_hold: got v=%0b d=0x%0h l=%0b expected v=1 d=0x%0h l=%0b",
                        out_tvalid, out_tdata, out_tlast, prevData, prevLast);
            end
         end
         if (out_tvalid && out_tready) begin
            checks++;
            if (expQ.size() == 0) begin
               failures++;
               $display("[TB] FAIL out_beat: got unexpected d=0x%0h l=%0b expected no beat",
                        out_tdata, out_tlast);
            end else begin
               e = expQ.pop_front();
               if (out_tdata !== e.data || out_tlast !== e.last) begin
                  failures++;
                  $display("[TB] FAIL out_beat: got d=0x%0h l=%0b expected d=0x%0h l=%0b",
                           out_tdata, out_tlast, e.data, e.last);
               end
            end
         end
         if (err_pulse) pulseSeen++;
         prevStall = out_tvalid && !out_tready;
         prevData  = out_tdata;
         prevLast  = out_tlast;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mkHdr(input logic [7:0] id, input int len);
      pkt_hdr_t h;
      h.id   = id;
      h.rsvd = {8'($urandom), 32'($urandom)};
      h.len  = 16'(len);
      return h;
   endfunction

   function automatic void bumpErr();
      expPulseTot++;
      if (expErrTot < ERR_MAX) expErrTot++;
   endfunction

   // Packet-level reference: a packet is good only with the right ID, a
   // length in 1..MAX_LEN, no tlast on the header and exactly len words.
   // Up to len words are forwarded, the final forwarded one carrying tlast.
   function automatic void modelPacket(input logic [7:0] id, input int len, input bit hdrLast,
                                       input logic [63:0] words[$]);
      int n;
      int nOut;
      n = words.size();
      if (id != GOOD_ID || len == 0 || len > MAX_LEN || hdrLast) begin
         bumpErr();
         return;
      end
      nOut = (n < len) ? n : len;
      for (int i = 0; i < nOut; i++) expQ.push_back('{words[i], (i == nOut - 1)});
      if (n == len) expPktTot++;
      else bumpErr();
   endfunction

   // Drive one beat starting at posedge+1; returns at posedge+1 after it is taken
   task automatic sendBeat(input logic [63:0] d, input logic l);
      int  waitCnt;
      logic acc;
      waitCnt = 0;
      acc = 1'b0;
      in_tdata  = d;
      in_tlast  = l;
      in_tvalid = 1'b1;
      while (!acc && waitCnt < 300) begin
         @(negedge clk);
         acc = in_tready;
         @(posedge clk);
         #1;
         waitCnt++;
      end
      in_tvalid = 1'b0;
      if (!acc) begin
         checks++;
         failures++;
         $display("[TB] FAIL in_accept: got no in_tready within %0d cycles expected acceptance", waitCnt);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] id, input int len, input bit hdrLast,
                                input logic [63:0] words[$]);
      sendBeat(mkHdr(id, len), hdrLast);
      for (int i = 0; i < words.size(); i++) sendBeat(words[i], (i == words.size() - 1));
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((out_tvalid || busy || expQ.size() != 0) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 2000) begin
         failures++;
         $display("[TB] FAIL drain: got busy=%0b pending=%0d after %0d cycles expected idle",
                  busy, expQ.size(), n);
         expQ.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, " pkt_count"}, 64'(pkt_count), 64'(expPktTot));
      checkOutput({tag, " err_count"}, 64'(err_count), 64'(expErrTot));
      checkOutput({tag, " err_pulses"}, 64'(pulseSeen), 64'(expPulseTot));
   endtask

   function automatic void randWords(output logic [63:0] q[$], input int n);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back({$urandom, $urandom});
   endfunction

   // Watchdog so the bench always ends on its own
   initial begin
      #400000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "[TB] watchdog expired");
   end

   vec_t        vecs[11];
   logic [63:0] words[$];
   logic [63:0] wA;
   logic [7:0]  rid;
   int          rlen;
   int          rn;
   bit          rhl;
   int          cls;

   initial begin
      // len, nWords, hdrLast, expOut, expErr, expPkt
      vecs[0]  = '{8'hF0,  3, 3, 1'b0,  3, 0, 1};
      vecs[1]  = '{8'hE0,  2, 2, 1'b0,  0, 1, 0};
      vecs[2]  = '{8'hF0,  3, 3, 1'b0,  3, 0, 1};
      vecs[3]  = '{8'hF0,  4, 2, 1'b0,  2, 1, 0};
      vecs[4]  = '{8'hF0,  2, 5, 1'b0,  2, 1, 0};
      vecs[5]  = '{8'hF0,  0, 1, 1'b0,  0, 1, 0};
      vecs[6]  = '{8'hF0, 65, 2, 1'b0,  0, 1, 0};
      vecs[7]  = '{8'hF0, 64, 64, 1'b0, 64, 0, 1};
      vecs[8]  = '{8'hF0,  1, 0, 1'b1,  0, 1, 0};
      vecs[9]  = '{8'hE0,  5, 0, 1'b1,  0, 1, 0};
      vecs[10] = '{8'hF0,  1, 1, 1'b0,  1, 0, 1};

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst out_tvalid", 64'(out_tvalid), 64'd0);
      checkOutput("rst out_tdata", out_tdata, 64'd0);
      checkOutput("rst out_tlast", 64'(out_tlast), 64'd0);
      checkOutput("rst in_tready", 64'(in_tready), 64'd0);
      checkOutput("rst busy", 64'(busy), 64'd0);
      checkOutput("rst pkt_len", 64'(pkt_len), 64'd0);
      checkOutput("rst err_pulse", 64'(err_pulse), 64'd0);
      checkCounters("rst");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      ena = 1'b1;

      // Basic packet with a one-cycle latency check on the first word
      readyMode = 0;
      @(posedge clk);
      #1;
      wA = 64'hAAAA_0000_1111_0001;
      expQ.push_back('{wA, 1'b0});
      expQ.push_back('{64'hBBBB_0000_2222_0002, 1'b0});
      expQ.push_back('{64'hCCCC_0000_3333_0003, 1'b1});
      expPktTot++;
      sendBeat(64'hF000_0000_0000_0003, 1'b0);
      checkOutput("hdr busy", 64'(busy), 64'd1);
      sendBeat(wA, 1'b0);
      checkOutput("lat out_tvalid", 64'(out_tvalid), 64'd1);
      checkOutput("lat out_tdata", out_tdata, wA);
      sendBeat(64'hBBBB_0000_2222_0002, 1'b0);
      sendBeat(64'hCCCC_0000_3333_0003, 1'b1);
      waitIdle();
      checkCounters("basic");
      checkOutput("basic pkt_len", 64'(pkt_len), 64'd3);

      // Table-driven vectors
      for (int v = 0; v < 11; v++) begin
         randWords(words, vecs[v].nWords);
         for (int i = 0; i < vecs[v].expOut; i++)
            expQ.push_back('{words[i], (i == vecs[v].expOut - 1)});
         expPktTot += 32'(vecs[v].expPkt);
         for (int i = 0; i < vecs[v].expErr; i++) bumpErr();
         applyStimulus(vecs[v].id, vecs[v].len, vecs[v].hdrLast, words);
         waitIdle();
         checkCounters($sformatf("vec%0d", v));
         checkOutput($sformatf("vec%0d pkt_len", v), 64'(pkt_len), 64'(vecs[v].len));
      end

      // Back-to-back maximum-length packets with a toggling consumer
      readyMode = 1;
      for (int p = 0; p < 2; p++) begin
         randWords(words, 64);
         modelPacket(GOOD_ID, 64, 1'b0, words);
         applyStimulus(GOOD_ID, 64, 1'b0, words);
      end
      waitIdle();
      checkCounters("b2b64");
      randWords(words, 3);
      modelPacket(GOOD_ID, 65, 1'b0, words);
      applyStimulus(GOOD_ID, 65, 1'b0, words);
      waitIdle();
      checkCounters("len65");

      // ena dropped mid-packet does not stop the payload
      readyMode = 0;
      randWords(words, 3);
      modelPacket(GOOD_ID, 3, 1'b0, words);
      sendBeat(mkHdr(GOOD_ID, 3), 1'b0);
      ena = 1'b0;
      for (int i = 0; i < 3; i++) sendBeat(words[i], (i == 2));
      waitIdle();
      checkCounters("ena_mid");
      checkOutput("ena_off in_tready", 64'(in_tready), 64'd0);
      ena = 1'b1;

      // Randomised packets against the packet-level model
      readyMode = 2;
      for (int p = 0; p < 40; p++) begin
         cls  = $urandom_range(0, 6);
         rid  = GOOD_ID;
         rhl  = 1'b0;
         rlen = $urandom_range(1, 16);
         rn   = rlen;
         case (cls)
            3: begin
               rid = 8'($urandom_range(0, 255));
               if (rid == GOOD_ID) rid = 8'h0F;
               rn = $urandom_range(1, 8);
            end
            4: begin
               rlen = $urandom_range(2, 16);
               rn   = $urandom_range(1, rlen - 1);
            end
            5: rn = rlen + $urandom_range(1, 4);
            6: begin
               rlen = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 300);
               rn   = $urandom_range(1, 4);
            end
            default: begin
            end
         endcase
         if ($urandom_range(0, 9) == 0) begin
            rhl = 1'b1;
            rn  = 0;
         end
         randWords(words, rn);
         modelPacket(rid, rlen, rhl, words);
         applyStimulus(rid, rlen, rhl, words);
         waitIdle();
         checkCounters($sformatf("rand%0d", p));
      end

      // clear_counters coinciding with a good packet's final word
      readyMode = 0;
      randWords(words, 2);
      expQ.push_back('{words[0], 1'b0});
      expQ.push_back('{words[1], 1'b1});
      sendBeat(mkHdr(GOOD_ID, 2), 1'b0);
      sendBeat(words[0], 1'b0);
      clear_counters = 1'b1;
      sendBeat(words[1], 1'b1);
      clear_counters = 1'b0;
      expPktTot = '0;
      expErrTot = 0;
      waitIdle();
      checkCounters("clear");

      // Reset in the middle of a len=8 payload
      randWords(words, 3);
      for (int i = 0; i < 3; i++) expQ.push_back('{words[i], 1'b0});
      sendBeat(mkHdr(GOOD_ID, 8), 1'b0);
      for (int i = 0; i < 3; i++) sendBeat(words[i], 1'b0);
      checkOutput("prerst out_tvalid", 64'(out_tvalid), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst out_tvalid", 64'(out_tvalid), 64'd0);
      checkOutput("midrst out_tdata", out_tdata, 64'd0);
      checkOutput("midrst busy", 64'(busy), 64'd0);
      checkOutput("midrst pkt_len", 64'(pkt_len), 64'd0);
      expQ.delete();
      expPktTot = '0;
      expErrTot = 0;
      checkCounters("midrst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      randWords(words, 2);
      modelPacket(GOOD_ID, 2, 1'b0, words);
      applyStimulus(GOOD_ID, 2, 1'b0, words);
      waitIdle();
      checkCounters("postrst");
      checkOutput("postrst pkt_len", 64'(pkt_len), 64'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
